// File: rtl/sar_value_finder.sv
// Successive-approximation search that drives a magnitude comparator's operand a and
// recovers the hidden value on operand b from the returned gt/lt/eq flags.
module sar_value_finder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err
);

    localparam int unsigned IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]    IdxMsb   = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] TrialMsb = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic {StIdle, StTest} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             exact_q, exact_d;
    logic             err_q, err_d;
    logic             flags_onehot;

    assign flags_onehot = ({cmp_gt, cmp_lt, cmp_eq} == 3'b100) ||
                          ({cmp_gt, cmp_lt, cmp_eq} == 3'b010) ||
                          ({cmp_gt, cmp_lt, cmp_eq} == 3'b001);

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        exact_d  = exact_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    trial_d  = TrialMsb;
                    idx_d    = IdxMsb;
                    busy_d   = 1'b1;
                    exact_d  = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    state_d  = StTest;
                end
            end
            StTest: begin
                if (!flags_onehot) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    trial_d  = '0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end else if (cmp_eq) begin
                    result_d = trial_q;
                    exact_d  = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end else if (idx_q != '0) begin
                    // gt means the current bit overshoots the target, so drop it
                    if (cmp_gt) begin
                        trial_d[idx_q] = 1'b0;
                    end
                    trial_d[idx_q - IW'(1)] = 1'b1;
                    idx_d = idx_q - IW'(1);
                end else begin
                    result_d = cmp_gt ? {trial_q[WIDTH-1:1], 1'b0} : trial_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            trial_q  <= '0;
            result_q <= '0;
            idx_q    <= IdxMsb;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            exact_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            exact_q  <= exact_d;
            err_q    <= err_d;
        end
    end

    assign trial  = trial_q;
    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign exact  = exact_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sar_value_finder.sv
// Bench for sar_value_finder: an ideal comparator model closes the loop and an
// arithmetic binary-search model predicts trial sequence, cycle count and outputs.
module tb_sar_value_finder;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] target = '0;
    logic         force_bad = 1'b0;
    logic         force_none = 1'b0;
    logic         cmp_gt, cmp_lt, cmp_eq;
    logic [W-1:0] trial, result;
    logic         busy, done, exact, err;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] exp_seq [W];
    int           exp_n;
    logic [W-1:0] exp_res;
    logic         exp_exact;

    always #5 clk = ~clk;

    // Ideal comparator with fault overrides
    assign cmp_gt = force_bad | (!force_none & (trial > target));
    assign cmp_lt = force_bad | (!force_none & (trial < target));
    assign cmp_eq = !force_bad & !force_none & (trial == target);

    sar_value_finder #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .exact  (exact),
        .err    (err)
    );

    // Binary search in plain integers: halve the step each probe
    task automatic model(input logic [W-1:0] tgt);
        int t;
        int tg;
        t = 1 << (W - 1);
        tg = int'(tgt);
        exp_n = 0;
        exp_exact = 1'b0;
        exp_res = '0;
        for (int k = W - 1; k >= 0; k--) begin
            exp_seq[exp_n] = W'(t);
            exp_n++;
            if (t == tg) begin
                exp_res = W'(t);
                exp_exact = 1'b1;
                return;
            end
            if (k > 0) t = (t < tg) ? t + (1 << (k - 1)) : t - (1 << (k - 1));
            else exp_res = (t < tg) ? W'(t) : W'(t - 1);
        end
    endtask

    task automatic do_search(input logic [W-1:0] tgt, input int poke,
                             input bit chain_out, input bit chain_in);
        int cyc;
        model(tgt);
        target = tgt;
        if (!chain_in) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        if (chain_in) begin
            vectors++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_restart: done=%b busy=%b, want done=0 busy=1", done, busy);
            end
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < int'(W) + 2) begin
            vectors++;
            if (cyc >= exp_n || trial !== exp_seq[cyc]) begin
                miscompares++;
                $display("FAIL trial_seq[%0d] tgt=%0d: got %0d want %0d", cyc, tgt, trial,
                         (cyc < exp_n) ? exp_seq[cyc] : 'x);
            end
            if (cyc == poke) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        vectors++;
        if (cyc != exp_n) begin
            miscompares++;
            $display("FAIL test_cycles tgt=%0d: got %0d want %0d", tgt, cyc, exp_n);
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_pulse tgt=%0d: got %b want 1", tgt, done);
        end
        vectors++;
        if (result !== exp_res || result !== tgt) begin
            miscompares++;
            $display("FAIL result tgt=%0d: got %0d want %0d", tgt, result, exp_res);
        end
        vectors++;
        if (exact !== exp_exact || err !== 1'b0) begin
            miscompares++;
            $display("FAIL flags tgt=%0d: got exact=%b err=%b want exact=%b err=0", tgt, exact,
                     err, exp_exact);
        end
        if (chain_out) begin
            start = 1'b1;
        end else begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || result !== tgt) begin
                miscompares++;
                $display("FAIL done_fall tgt=%0d: got done=%b result=%0d want done=0 result=%0d",
                         tgt, done, result, tgt);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({trial, busy, done, result, exact, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: got %b want 0", {trial, busy, done, result, exact, err});
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({trial, busy, done, result, exact, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_release: got %b want 0", {trial, busy, done, result, exact, err});
        end
    endtask

    task automatic test_directed();
        do_search(4'd8, -1, 1'b0, 1'b0);
        do_search(4'd5, -1, 1'b0, 1'b0);
        do_search(4'd0, -1, 1'b0, 1'b0);
        do_search(4'd15, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) do_search(W'($urandom_range(0, 15)), -1, 1'b0, 1'b0);
    endtask

    task automatic test_error();
        // Both gt and lt in the second probe
        target = W'($urandom_range(0, 7));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        force_bad = 1'b1;
        @(negedge clk);
        force_bad = 1'b0;
        vectors++;
        if ({err, done, busy, result, trial} !== {3'b110, {W{1'b0}}, {W{1'b0}}}) begin
            miscompares++;
            $display("FAIL err_multi: got err=%b done=%b busy=%b result=%0d trial=%0d",
                     err, done, busy, result, trial);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_hold: got done=%b err=%b want done=0 err=1", done, err);
        end
        // No flag at all in the first probe
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        force_none = 1'b1;
        @(negedge clk);
        force_none = 1'b0;
        vectors++;
        if ({err, done, busy, result, trial} !== {3'b110, {W{1'b0}}, {W{1'b0}}}) begin
            miscompares++;
            $display("FAIL err_none: got err=%b done=%b busy=%b result=%0d trial=%0d",
                     err, done, busy, result, trial);
        end
        do_search(W'($urandom_range(0, 15)), -1, 1'b0, 1'b0);
    endtask

    task automatic test_restart_ignored();
        do_search(4'd5, 1, 1'b0, 1'b0);
        do_search(W'($urandom_range(0, 15)), 2, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_search(4'd6, -1, 1'b1, 1'b0);
        do_search(4'd11, -1, 1'b1, 1'b1);
        do_search(W'($urandom_range(0, 15)), -1, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        do_search(4'd9, -1, 1'b0, 1'b0);
        target = 4'd6;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({trial, busy, done, result, exact, err} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %b want 0", {trial, busy, done, result, exact, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_search(4'd3, -1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_error();
        test_restart_ignored();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
